// File: rtl/spi_slave_ctrl.sv
`timescale 1ns/1ps
// spi_slave_ctrl
//   Parametrised full-duplex SPI slave between the external SPI master and
//   the internal command/data FIFOs. Supports 4..32 bit words, all four SPI
//   modes and either bit order.
//
// Ports
//   clk_i, rst_i          system clock, asynchronous active-high reset
//   tx_data_i/valid_i     word offered to the tx holding register
//   tx_ready_o            holding register empty
//   tx_underrun_o         pulse: IDLE_WORD loaded because holding was empty
//   rx_data_o/valid_o     last complete received word / update pulse
//   frame_active_o        frame in progress (synchronised CS asserted)
//   frame_end_o/err_o     pulse at frame end / frame ended mid-word
//   word_cnt_o            words completed in current or last frame (saturating)
//   sclk_i, sncs_i        SPI clock and active-low chip select (asynchronous)
//   sdata_s_i/o, oe_o     MOSI, MISO, MISO output enable
module spi_slave_ctrl #(
  parameter int unsigned        DATA_W    = 8,
  parameter bit                 CPOL      = 1'b0,
  parameter bit                 CPHA      = 1'b0,
  parameter bit                 MSB_FIRST = 1'b1,
  parameter logic [DATA_W-1:0]  IDLE_WORD = '0,
  parameter int unsigned        CNT_W     = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              tx_underrun_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              frame_active_o,
  output logic              frame_end_o,
  output logic              frame_err_o,
  output logic [CNT_W-1:0]  word_cnt_o,
  input  logic              sclk_i,
  input  logic              sncs_i,
  input  logic              sdata_s_i,
  output logic              sdata_s_o,
  output logic              sdata_oe_o
);

  localparam int unsigned BC_W = $clog2(DATA_W);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;
  state_t state_q, state_d;

  logic sclk_m, sclk_s, sclk_d;
  logic ncs_m, ncs_s, ncs_d;
  logic mosi_m, mosi_s;

  logic [DATA_W-1:0] hold_q;
  logic              hold_full;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] tx_shifted;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] rx_next;
  logic [BC_W-1:0]   bit_cnt;

  logic rise, fall, lead, trail, samp_e, shift_e;
  logic start, stop, run, load, shift_adv, sample, word_done, tx_wr;

  // ncs_d resets to 0 (asserted), so a CS already low at reset release never
  // produces the high->low transition needed to start a frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_m <= 1'b0; sclk_s <= 1'b0; sclk_d <= 1'b0;
      ncs_m  <= 1'b0; ncs_s  <= 1'b0; ncs_d  <= 1'b0;
      mosi_m <= 1'b0; mosi_s <= 1'b0;
    end else begin
      sclk_m <= sclk_i;    sclk_s <= sclk_m; sclk_d <= sclk_s;
      ncs_m  <= sncs_i;    ncs_s  <= ncs_m;  ncs_d  <= ncs_s;
      mosi_m <= sdata_s_i; mosi_s <= mosi_m;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    stop    = 1'b0;
    rise    = sclk_s & ~sclk_d;
    fall    = ~sclk_s & sclk_d;
    lead    = CPOL ? fall : rise;
    trail   = CPOL ? rise : fall;
    samp_e  = CPHA ? trail : lead;
    shift_e = CPHA ? lead : trail;
    case (state_q)
      S_IDLE: begin
        if (ncs_d && !ncs_s) begin
          state_d = S_ACTIVE;
          start   = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (ncs_s) begin
          state_d = S_IDLE;
          stop    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    run       = (state_q == S_ACTIVE) && !ncs_s;
    // A shift edge with the bit counter at 0 is the first shift edge of a
    // word (CPHA=1) or the one right after the last sample (CPHA=0).
    load      = (start && !CPHA) || (run && shift_e && (bit_cnt == '0));
    shift_adv = run && shift_e && (bit_cnt != '0);
    sample    = run && samp_e;
    word_done = sample && (bit_cnt == BC_W'(DATA_W - 1));
    tx_wr     = tx_valid_i && !hold_full;
    if (MSB_FIRST) begin
      tx_shifted = {tx_sr[DATA_W-2:0], 1'b0};
      rx_next    = {rx_sr[DATA_W-2:0], mosi_s};
    end else begin
      tx_shifted = {1'b0, tx_sr[DATA_W-1:1]};
      rx_next    = {mosi_s, rx_sr[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_q        <= '0;
      hold_full     <= 1'b0;
      tx_sr         <= IDLE_WORD;
      tx_underrun_o <= 1'b0;
      rx_sr         <= '0;
      rx_data_o     <= '0;
      rx_valid_o    <= 1'b0;
      bit_cnt       <= '0;
      word_cnt_o    <= '0;
      frame_end_o   <= 1'b0;
      frame_err_o   <= 1'b0;
    end else begin
      tx_underrun_o <= 1'b0;
      rx_valid_o    <= 1'b0;
      frame_end_o   <= 1'b0;
      frame_err_o   <= 1'b0;

      // tx_wr needs an empty holding register, so it never collides with a
      // load that drains a full one; a write during an underrun load is kept.
      if (tx_wr) begin
        hold_q    <= tx_data_i;
        hold_full <= 1'b1;
      end
      if (load) begin
        if (hold_full) begin
          tx_sr     <= hold_q;
          hold_full <= 1'b0;
        end else begin
          tx_sr         <= IDLE_WORD;
          tx_underrun_o <= 1'b1;
        end
      end else if (shift_adv) begin
        tx_sr <= tx_shifted;
      end

      if (start) begin
        bit_cnt    <= '0;
        word_cnt_o <= '0;
      end else if (sample) begin
        rx_sr <= rx_next;
        if (word_done) begin
          bit_cnt    <= '0;
          rx_data_o  <= rx_next;
          rx_valid_o <= 1'b1;
          if (word_cnt_o != '1) word_cnt_o <= word_cnt_o + CNT_W'(1);
        end else begin
          bit_cnt <= bit_cnt + BC_W'(1);
        end
      end

      if (stop) begin
        frame_end_o <= 1'b1;
        frame_err_o <= (bit_cnt != '0);
      end
    end
  end

  assign tx_ready_o     = ~hold_full;
  assign frame_active_o = (state_q == S_ACTIVE);
  assign sdata_oe_o     = frame_active_o;
  assign sdata_s_o      = frame_active_o ? (MSB_FIRST ? tx_sr[DATA_W-1] : tx_sr[0]) : 1'b0;

endmodule
